subleq_sequencer: RTL

- Control sequencer for the SUBLEQ CPU. It drives register-card select lines, memory strobes and the data bus.
- It steps through fetch, operand read, subtract/write-back and branch, one micro-step per clock.
- It holds an internal PC shadow, the branch target and the operand latches. The register card holds architectural PC/A/B and supplies the address bus.

---
 rtl/subleq_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/subleq_sequencer.sv
// rtl/subleq_sequencer.sv - SUBLEQ micro-step sequencer (optional single-step via SEQ_STEP_EN)
module subleq_sequencer #(
    parameter int                   DATAWIDTH = 16,
    parameter logic [DATAWIDTH-1:0] HALT_ADDR = {DATAWIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] data_in,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 data_oe,
    output logic [1:0]           reg_wr_sel,
    output logic [1:0]           reg_rd_sel,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 halted,
    input  logic                 step
);

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_PC   = 2'd1;
    localparam logic [1:0] SEL_A    = 2'd2;
    localparam logic [1:0] SEL_B    = 2'd3;

    // EXEC gives the freshly latched B operand a cycle before the write data is
    // registered; EXEC/WREC also hold the B address stable around the write strobe.
    typedef enum logic [4:0] {
        S_INIT, S_FA_ADDR, S_FA_DATA, S_INC1, S_FB_ADDR, S_FB_DATA, S_INC2,
        S_FC_ADDR, S_FC_DATA, S_OA_ADDR, S_OA_DATA, S_OB_ADDR, S_OB_DATA,
        S_EXEC, S_WRITE, S_WREC, S_BRANCH, S_HALT
    } state_t;

    state_t               state;
    state_t               next_state;
    logic                 armed;
    logic [DATAWIDTH-1:0] pc_shadow;
    logic [DATAWIDTH-1:0] c_lat;
    logic [DATAWIDTH-1:0] op_a;
    logic [DATAWIDTH-1:0] op_b;

    logic [DATAWIDTH-1:0] result;
    logic [DATAWIDTH-1:0] pc_inc;
    logic [DATAWIDTH-1:0] next_pc;
    logic                 taken;

    logic [DATAWIDTH-1:0] data_out_d;
    logic                 data_oe_d;
    logic [1:0]           reg_wr_sel_d;
    logic [1:0]           reg_rd_sel_d;
    logic                 mem_rd_d;
    logic                 mem_wr_d;
    logic                 halted_d;

    assign result  = op_b - op_a;
    assign pc_inc  = pc_shadow + 1'b1;
    assign taken   = result[DATAWIDTH-1] | (result == '0);
    assign next_pc = taken ? c_lat : pc_inc;

`ifndef SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    // State register; armed keeps INIT for the first edge so its outputs get presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= 1'b1;
        end
    end

    // Next-state: linear micro-step walk, halt on taken branch to HALT_ADDR
    always_comb begin
        next_state = state;
        unique case (state)
            S_INIT:    next_state = armed ? S_FA_ADDR : S_INIT;
`ifdef SEQ_STEP_EN
            S_FA_ADDR: next_state = step ? S_FA_DATA : S_FA_ADDR;
`else
            S_FA_ADDR: next_state = S_FA_DATA;
`endif
            S_FA_DATA: next_state = S_INC1;
            S_INC1:    next_state = S_FB_ADDR;
            S_FB_ADDR: next_state = S_FB_DATA;
            S_FB_DATA: next_state = S_INC2;
            S_INC2:    next_state = S_FC_ADDR;
            S_FC_ADDR: next_state = S_FC_DATA;
            S_FC_DATA: next_state = S_OA_ADDR;
            S_OA_ADDR: next_state = S_OA_DATA;
            S_OA_DATA: next_state = S_OB_ADDR;
            S_OB_ADDR: next_state = S_OB_DATA;
            S_OB_DATA: next_state = S_EXEC;
            S_EXEC:    next_state = S_WRITE;
            S_WRITE:   next_state = S_WREC;
            S_WREC:    next_state = S_BRANCH;
            S_BRANCH:  next_state = (taken && (c_lat == HALT_ADDR)) ? S_HALT : S_FA_ADDR;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_INIT;
        endcase
    end

    // Output decode of the state being entered, so registered outputs match the state
    always_comb begin
        data_out_d   = '0;
        data_oe_d    = 1'b0;
        reg_wr_sel_d = SEL_NONE;
        reg_rd_sel_d = SEL_NONE;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        halted_d     = 1'b0;
        unique case (next_state)
            S_INIT: begin
                data_oe_d    = 1'b1;
                reg_wr_sel_d = SEL_PC;
            end
            S_FA_ADDR, S_FB_ADDR, S_FC_ADDR: reg_rd_sel_d = SEL_PC;
            S_FA_DATA: begin
                reg_rd_sel_d = SEL_PC;
                mem_rd_d     = 1'b1;
                reg_wr_sel_d = SEL_A;
            end
            S_FB_DATA: begin
                reg_rd_sel_d = SEL_PC;
                mem_rd_d     = 1'b1;
                reg_wr_sel_d = SEL_B;
            end
            S_FC_DATA: begin
                reg_rd_sel_d = SEL_PC;
                mem_rd_d     = 1'b1;
            end
            S_INC1, S_INC2: begin
                data_out_d   = pc_inc;
                data_oe_d    = 1'b1;
                reg_wr_sel_d = SEL_PC;
            end
            S_OA_ADDR: reg_rd_sel_d = SEL_A;
            S_OA_DATA: begin
                reg_rd_sel_d = SEL_A;
                mem_rd_d     = 1'b1;
            end
            S_OB_ADDR, S_EXEC, S_WREC: reg_rd_sel_d = SEL_B;
            S_OB_DATA: begin
                reg_rd_sel_d = SEL_B;
                mem_rd_d     = 1'b1;
            end
            S_WRITE: begin
                reg_rd_sel_d = SEL_B;
                data_out_d   = result;
                data_oe_d    = 1'b1;
                mem_wr_d     = 1'b1;
            end
            S_BRANCH: begin
                data_out_d   = next_pc;
                data_oe_d    = 1'b1;
                reg_wr_sel_d = SEL_PC;
            end
            S_HALT:  halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    // Output registers give the falling-edge register card a half cycle of setup
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_oe    <= 1'b0;
            reg_wr_sel <= SEL_NONE;
            reg_rd_sel <= SEL_NONE;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            data_out   <= data_out_d;
            data_oe    <= data_oe_d;
            reg_wr_sel <= reg_wr_sel_d;
            reg_rd_sel <= reg_rd_sel_d;
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
            halted     <= halted_d;
        end
    end

    // Datapath latches update as each micro-step completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_shadow <= '0;
            c_lat     <= '0;
            op_a      <= '0;
            op_b      <= '0;
        end else begin
            unique case (state)
                S_INC1, S_INC2: pc_shadow <= pc_inc;
                S_FC_DATA:      c_lat     <= data_in;
                S_OA_DATA:      op_a      <= data_in;
                S_OB_DATA:      op_b      <= data_in;
                S_BRANCH:       pc_shadow <= next_pc;
                default:        pc_shadow <= pc_shadow;
            endcase
        end
    end

endmodule
